// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core. The decoder, the sequencer and the
// trace tooling use the same opcode constants and 3-bit state encoding.
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  // Opcodes that finish without a data-memory access.
  function automatic logic is_alu_class(input logic [6:0] op);
    return (op == OP_OP)    || (op == OP_OPIMM) || (op == OP_JALR)  ||
           (op == OP_LUI)   || (op == OP_AUIPC) || (op == OP_JAL)   ||
           (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// Handshake wait counter: counts stalled cycles, flags the last permitted
// wait cycle so the sequencer can fault instead of waiting forever.
module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (count_en) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired = (count_reg == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer: steps each instruction through FETCH, EXEC, optional
// MEM and WB, owning the memory handshakes and the PC/regfile commit strobes.
module core_sequencer
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        ir_load,
  input  logic [6:0]  opcode,
  input  logic        ctrl_reg_write,
  input  logic        ctrl_mem_write,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        pc_write_enable,
  output logic        rf_write_enable,
  output logic        retired,
  output logic [31:0] retired_count,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  state_t      state_reg, state_next;
  logic [31:0] retired_count_reg;
  logic        timer_clear, timer_count, timer_expired;

  wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .count_en (timer_count),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      retired_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_WB) begin
        retired_count_reg <= retired_count_reg + 32'd1;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    imem_req        = 1'b0;
    ir_load         = 1'b0;
    dmem_req        = 1'b0;
    dmem_we         = 1'b0;
    pc_write_enable = 1'b0;
    rf_write_enable = 1'b0;
    retired         = 1'b0;
    halted          = 1'b0;
    fault           = 1'b0;
    timer_count     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        // A ready arriving on the last permitted wait cycle still wins.
        if (imem_ready) begin
          ir_load    = 1'b1;
          state_next = ST_EXEC;
        end else if (timer_expired) begin
          state_next = ST_FAULT;
        end else begin
          timer_count = 1'b1;
        end
      end
      ST_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) state_next = ST_MEM;
        else if (is_alu_class(opcode))               state_next = ST_WB;
        else if (opcode == OP_SYSTEM)                state_next = ST_HALT;
        else                                         state_next = ST_FAULT;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl_mem_write & (opcode == OP_STORE);
        if (dmem_ready) begin
          state_next = ST_WB;
        end else if (timer_expired) begin
          state_next = ST_FAULT;
        end else begin
          timer_count = 1'b1;
        end
      end
      ST_WB: begin
        pc_write_enable = 1'b1;
        rf_write_enable = ctrl_reg_write & (opcode != OP_STORE);
        retired         = 1'b1;
        state_next      = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      ST_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: begin
        state_next = ST_FAULT;
      end
    endcase
  end

  // Every phase change restarts the wait budget for the next handshake.
  assign timer_clear   = (state_next != state_reg);
  assign retired_count = retired_count_reg;
  assign state         = state_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer (MEM_TIMEOUT=4): ALU stream, load, store,
// run drop, mid-fetch reset, fetch timeout, HALT and illegal-opcode FAULT.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, imem_ready, ctrl_reg_write, ctrl_mem_write, dmem_ready;
  logic [6:0]  opcode;
  logic        imem_req, ir_load, dmem_req, dmem_we;
  logic        pc_write_enable, rf_write_enable, retired, halted, fault;
  logic [31:0] retired_count;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  core_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .imem_req        (imem_req),
    .imem_ready      (imem_ready),
    .ir_load         (ir_load),
    .opcode          (opcode),
    .ctrl_reg_write  (ctrl_reg_write),
    .ctrl_mem_write  (ctrl_mem_write),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_ready      (dmem_ready),
    .pc_write_enable (pc_write_enable),
    .rf_write_enable (rf_write_enable),
    .retired         (retired),
    .retired_count   (retired_count),
    .halted          (halted),
    .fault           (fault),
    .state           (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge,
  // and inputs changed there settle before the next comparison.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cycle %0d: state=%0d retired=%0b count=%0d", cyc, state, retired, retired_count);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"}, {29'd0, state}, 32'd0);
    check_eq({tag, "_strobes"},
             {24'd0, imem_req, ir_load, dmem_req, dmem_we, pc_write_enable,
              rf_write_enable, retired, halted | fault}, 32'd0);
    check_eq({tag, "_count"}, retired_count, 32'd0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; ctrl_reg_write = 1'b0;
    ctrl_mem_write = 1'b0; dmem_ready = 1'b0; opcode = 7'd0;
    step(); step();
    check_all_zero("reset");

    // ALU stream: FETCH, EXEC, WB repeating with everything ready.
    rst = 1'b0;
    step();
    check_eq("idle_hold", {29'd0, state}, 32'd0);
    run = 1'b1; imem_ready = 1'b1; opcode = 7'b0110011; ctrl_reg_write = 1'b1;
    step();
    check_eq("first_fetch", {29'd0, state}, 32'd1);
    check_eq("fetch_req", {31'd0, imem_req & ir_load}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      logic [2:0] exp_st;
      exp_st = (i % 3 == 0) ? 3'd1 : (i % 3 == 1) ? 3'd2 : 3'd4;
      check_eq("alu_state", {29'd0, state}, {29'd0, exp_st});
      check_eq("alu_retired", {31'd0, retired}, {31'd0, (i % 3 == 2)});
      step();
    end
    check_eq("alu_count3", retired_count, 32'd3);
    check_eq("alu_refetch", {29'd0, state}, 32'd1);

    // Load: dmem_ready two cycles after MEM entry, six cycles in total.
    opcode = 7'b0000011; ctrl_mem_write = 1'b0; dmem_ready = 1'b0;
    step();
    check_eq("ld_exec", {29'd0, state}, 32'd2);
    step();
    check_eq("ld_mem1", {29'd0, state}, 32'd3);
    check_eq("ld_req1", {30'd0, dmem_req, dmem_we}, 32'b10);
    step();
    check_eq("ld_req2", {30'd0, dmem_req, dmem_we}, 32'b10);
    step();
    dmem_ready = 1'b1;
    #1;
    check_eq("ld_req3", {30'd0, dmem_req, dmem_we}, 32'b10);
    step();
    dmem_ready = 1'b0;
    #1;
    check_eq("ld_wb", {29'd0, state}, 32'd4);
    check_eq("ld_rf_we", {29'd0, rf_write_enable, pc_write_enable, retired}, 32'b111);
    step();
    check_eq("ld_count", retired_count, 32'd4);

    // Store: dmem_we in MEM, no register write in WB.
    opcode = 7'b0100011; ctrl_mem_write = 1'b1; dmem_ready = 1'b1;
    step();
    step();
    check_eq("st_mem", {29'd0, state}, 32'd3);
    check_eq("st_we", {30'd0, dmem_req, dmem_we}, 32'b11);
    step();
    check_eq("st_wb", {29'd0, rf_write_enable, pc_write_enable, retired}, 32'b011);
    step();
    check_eq("st_count", retired_count, 32'd5);

    // run dropped during MEM: load still retires, then IDLE.
    opcode = 7'b0000011; ctrl_mem_write = 1'b0; dmem_ready = 1'b0;
    step();
    step();
    check_eq("rd_mem", {29'd0, state}, 32'd3);
    run = 1'b0;
    step();
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    #1;
    check_eq("rd_retire", {31'd0, retired}, 32'd1);
    step();
    check_eq("rd_idle", {29'd0, state}, 32'd0);
    check_eq("rd_count", retired_count, 32'd6);

    // Reset asserted inside a stalled FETCH.
    run = 1'b1; imem_ready = 1'b0;
    step();
    check_eq("rs_fetch", {29'd0, state}, 32'd1);
    rst = 1'b1;
    step();
    check_all_zero("midreset");

    // Fetch timeout: four waiting FETCH cycles, then FAULT.
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq("to_fetch", {29'd0, state}, 32'd1);
      step();
    end
    check_eq("to_fault", {29'd0, state}, 32'd6);
    check_eq("to_flags", {30'd0, halted, fault}, 32'b11);
    run = 1'b0;
    step(); step();
    check_eq("to_sticky", {29'd0, state}, 32'd6);

    // Ready on the fourth waiting cycle wins over the timeout.
    rst = 1'b1; run = 1'b1;
    step();
    rst = 1'b0;
    step();
    step(); step(); step();
    imem_ready = 1'b1;
    opcode = 7'b1110011;
    #1;
    check_eq("late_ready", {29'd0, state, ir_load}, 32'b0011);
    step();
    check_eq("late_exec", {29'd0, state}, 32'd2);

    // SYSTEM opcode halts without retiring and stays halted.
    step();
    check_eq("halt_state", {29'd0, state}, 32'd5);
    check_eq("halt_flags", {29'd0, halted, fault, retired}, 32'b100);
    step(); step();
    check_eq("halt_sticky", {29'd0, state}, 32'd5);
    check_eq("halt_count", retired_count, 32'd0);

    // Illegal opcode faults and stays faulted until reset.
    rst = 1'b1;
    step();
    rst = 1'b0; opcode = 7'b0000000;
    step();
    step();
    check_eq("ill_exec", {29'd0, state}, 32'd2);
    step();
    check_eq("ill_fault", {29'd0, state, halted, fault}, {27'd0, 3'd6, 2'b11});
    step(); step();
    check_eq("ill_sticky", {29'd0, state}, 32'd6);
    rst = 1'b1;
    step();
    check_all_zero("final_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle sequencer for the RV32I core datapath: steps each instruction through fetch, execute, optional data-memory access and write-back. Owns the instruction/data memory request handshakes and gates PC and register-file updates. Sits beside the combinational instruction decoder, consuming its opcode and write enables, and issues the per-phase strobes the single-cycle datapath lacks.

Parameters:
MEM_TIMEOUT, 255, wait cycles allowed on imem/dmem handshake before fault (legal range 1..65535)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous reset, active-high
run  in  1  level; enables starting new instructions
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
ir_load  out  1  load instruction register from imem data this cycle
opcode  in  7  instruction[6:0] from instruction register
ctrl_reg_write  in  1  register_write_enable from decoder
ctrl_mem_write  in  1  memory_write_enable from decoder
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write qualifier
dmem_ready  in  1  data access complete this cycle
pc_write_enable  out  1  commit next PC
rf_write_enable  out  1  commit register write
retired  out  1  one-cycle pulse per completed instruction
retired_count  out  32  completed-instruction count
halted  out  1  sticky; core stopped
fault  out  1  sticky; illegal opcode or handshake timeout
state  out  3  current state, debug

Behaviour:
- States: IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6. Only state, wait counter and retired_count are registered; all other outputs decode combinationally from state and inputs.
- Reset: state IDLE, wait counter 0, retired_count 0; hence every output 0. Reset mid-operation aborts the instruction next edge; outstanding requests drop without completion.
- IDLE: run=1 -> FETCH, else stay.
- FETCH: imem_req=1. imem_ready=1 -> ir_load=1, -> EXEC. Else wait counter +1.
- EXEC: no strobes. Opcode 0000011 (load) or 0100011 (store) -> MEM. Opcodes 0110011, 0010011, 1100111, 0110111, 0010111, 1101111, 1100011 -> WB. 1110011 (system) -> HALT. Any other -> FAULT.
- MEM: dmem_req=1, dmem_we=ctrl_mem_write & (opcode==0100011). dmem_ready=1 -> WB, else wait counter +1.
- WB: pc_write_enable=1, rf_write_enable=ctrl_reg_write & (opcode!=0100011), retired=1, retired_count+1 (wraps 0xFFFFFFFF->0). Next: run ? FETCH : IDLE.
- run deasserting mid-instruction: current instruction completes; stop at WB -> IDLE.
- Wait counter: cleared on every entry into FETCH or MEM. Timeout when ready=0 and counter==MEM_TIMEOUT-1 -> FAULT (MEM_TIMEOUT waiting cycles exhausted). Ready in that same cycle wins: normal transition.
- HALT: halted=1, fault=0. FAULT: halted=1, fault=1. Both terminal until rst; run ignored.
- Latency with zero-wait memory: non-memory instruction 3 cycles (FETCH, EXEC, WB), load/store 4. Back-to-back throughput with run held: one retire per 3 or 4 cycles.

Decomposition:
- Shared package core_pkg: opcode constants (OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL, OP_BRANCH, OP_SYSTEM) and the 3-bit state encoding, shared with the decoder and trace tooling.
- One sub-module: wait_timer (clear, count enable, expired output; width from MEM_TIMEOUT).

Test Plan:
- Reset, run=1, imem_ready=1 always, opcode 0110011, ctrl_reg_write=1 -> states 1,2,4 repeating; retired every 3rd cycle; retired_count=3 after 9 cycles from first FETCH.
- Load: opcode 0000011, dmem_ready asserted 2 cycles after MEM entry -> dmem_req high 3 cycles, dmem_we=0, rf_write_enable=1 in WB, 6 cycles total.
- Store: opcode 0100011, ctrl_mem_write=1, ctrl_reg_write=1 -> dmem_we=1 in MEM, rf_write_enable=0 in WB.
- MEM_TIMEOUT=4, imem_ready held 0 -> FAULT after 4 FETCH cycles, fault=halted=1; ready on 4th cycle -> EXEC instead.
- Opcode 1110011 -> HALT, halted=1, fault=0, no retire; opcode 0000000 -> FAULT; both persist until rst.
- run dropped during MEM, then rst asserted inside a later FETCH -> instruction retires, IDLE; rst returns all outputs and retired_count to 0 next edge.
